// File: rtl/exp_avg_pkg.sv
// Shared types and constants for the exponential-average bank.
package exp_avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  localparam int MAX_SHIFT_DEF = 5;

  function automatic int acc_width(input int smpl_w, input int max_shift);
    return smpl_w + max_shift;
  endfunction

endpackage

// File: rtl/exp_avg_rr_arb.sv
// Round-robin arbiter: searches from ptr_q upward, pointer moves past the
// granted index when the grant is accepted.
module exp_avg_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             accept,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               cand;

  // Scan from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    for (int j = N - 1; j >= 0; j--) begin
      cand = (int'(ptr_q) + j) % N;
      if (req[IDX_W'(cand)]) begin
        gnt                 = '0;
        gnt[IDX_W'(cand)]   = 1'b1;
        gnt_idx             = IDX_W'(cand);
        gnt_vld             = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && gnt_vld) begin
      if (int'(gnt_idx) == N - 1) ptr_d = '0;
      else                        ptr_d = IDX_W'(int'(gnt_idx) + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/exp_avg_bank.sv
// Multi-channel exponential averager sharing one update datapath.
// Optional magnitude snap-to-sample enabled by macro EXP_AVG_SNAP_EN.
module exp_avg_bank
  import exp_avg_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int SMPL_W    = 12,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*SMPL_W-1:0] smpl,
  input  logic [NUM_CH-1:0]        smpl_req,
  input  logic [NUM_CH-1:0]        reseed,
  input  logic [NUM_CH*3-1:0]      shift,
  input  logic                     ovr_clr,
`ifdef EXP_AVG_SNAP_EN
  input  logic [SMPL_W-1:0]        snap_thr,
`endif
  output logic [NUM_CH*SMPL_W-1:0] avg,
  output logic [NUM_CH-1:0]        avg_vld,
  output logic [NUM_CH-1:0]        ovr,
  output logic                     busy
);

  localparam int ACC_W = acc_width(SMPL_W, MAX_SHIFT);
  localparam int SUM_W = ACC_W + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                          state_q, state_d;
  logic [NUM_CH-1:0]               pend_q, pend_d;
  logic [NUM_CH-1:0]               rsd_q, rsd_d;
  logic [NUM_CH-1:0]               ovr_q, ovr_d;
  logic [NUM_CH-1:0][SMPL_W-1:0]   hold_q, hold_d;
  logic [NUM_CH-1:0][ACC_W-1:0]    acc_q, acc_d;
  logic [NUM_CH-1:0][SMPL_W-1:0]   avg_q, avg_d;
  logic [NUM_CH-1:0]               vld_q, vld_d;
  logic [IDX_W-1:0]                op_idx_q, op_idx_d;
  logic [SMPL_W-1:0]               op_smpl_q, op_smpl_d;
  logic [ACC_W-1:0]                op_acc_q, op_acc_d;
  logic                            op_rsd_q, op_rsd_d;
  logic [2:0]                      op_k_q, op_k_d;

  logic [NUM_CH-1:0] new_req, gnt, load_take;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld, accept, any_work, snap;
  logic [2:0]        sh_raw;
  logic [SUM_W-1:0]  upd_sum;
  logic [ACC_W-1:0]  acc_new;
  logic [SMPL_W-1:0] avg_new;
`ifdef EXP_AVG_SNAP_EN
  logic [SMPL_W-1:0] cur_avg, diff;
`endif

  assign new_req   = smpl_req | reseed;
  assign accept    = (state_q == ST_LOAD) && gnt_vld;
  assign load_take = accept ? gnt : '0;
  assign any_work  = (|pend_q) || (|new_req);

  exp_avg_rr_arb #(.N(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pend_q),
    .accept  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_work) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_UPDATE;
      ST_UPDATE: state_d = any_work ? ST_LOAD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A request landing on the channel being granted this cycle loses nothing.
  always_comb begin
    pend_d = pend_q;
    rsd_d  = rsd_q;
    hold_d = hold_q;
    ovr_d  = ovr_clr ? '0 : ovr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_take[i]) pend_d[i] = 1'b0;
      if (new_req[i]) begin
        pend_d[i] = 1'b1;
        rsd_d[i]  = reseed[i];
        hold_d[i] = smpl[i*SMPL_W +: SMPL_W];
        if (pend_q[i] && !load_take[i]) ovr_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    op_idx_d  = op_idx_q;
    op_smpl_d = op_smpl_q;
    op_acc_d  = op_acc_q;
    op_rsd_d  = op_rsd_q;
    op_k_d    = op_k_q;
    sh_raw    = shift[gnt_idx*3 +: 3];
    if (accept) begin
      op_idx_d  = gnt_idx;
      op_smpl_d = hold_q[gnt_idx];
      op_acc_d  = acc_q[gnt_idx];
      op_rsd_d  = rsd_q[gnt_idx];
      op_k_d    = (int'(sh_raw) > MAX_SHIFT) ? 3'(MAX_SHIFT) : sh_raw;
    end
  end

  always_comb begin
    snap = 1'b0;
`ifdef EXP_AVG_SNAP_EN
    cur_avg = avg_q[op_idx_q];
    diff    = (op_smpl_q > cur_avg) ? (op_smpl_q - cur_avg) : (cur_avg - op_smpl_q);
    snap    = (diff > snap_thr);
`endif
    upd_sum = {1'b0, op_acc_q} - {1'b0, (op_acc_q >> op_k_q)} + SUM_W'(op_smpl_q);
    if (op_rsd_q || snap)  acc_new = ACC_W'(op_smpl_q) << op_k_q;
    else if (upd_sum[ACC_W]) acc_new = '1;
    else                   acc_new = upd_sum[ACC_W-1:0];
    avg_new = SMPL_W'(acc_new >> op_k_q);
  end

  always_comb begin
    acc_d = acc_q;
    avg_d = avg_q;
    vld_d = '0;
    if (state_q == ST_UPDATE) begin
      acc_d[op_idx_q] = acc_new;
      avg_d[op_idx_q] = avg_new;
      vld_d[op_idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      rsd_q     <= '0;
      ovr_q     <= '0;
      hold_q    <= '0;
      acc_q     <= '0;
      avg_q     <= '0;
      vld_q     <= '0;
      op_idx_q  <= '0;
      op_smpl_q <= '0;
      op_acc_q  <= '0;
      op_rsd_q  <= 1'b0;
      op_k_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      rsd_q     <= rsd_d;
      ovr_q     <= ovr_d;
      hold_q    <= hold_d;
      acc_q     <= acc_d;
      avg_q     <= avg_d;
      vld_q     <= vld_d;
      op_idx_q  <= op_idx_d;
      op_smpl_q <= op_smpl_d;
      op_acc_q  <= op_acc_d;
      op_rsd_q  <= op_rsd_d;
      op_k_q    <= op_k_d;
    end
  end

  assign avg     = avg_q;
  assign avg_vld = vld_q;
  assign ovr     = ovr_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exp_avg_bank.sv
// Directed self-checking bench for exp_avg_bank (default 4 channels, 12-bit).
module tb_exp_avg_bank;
  localparam int NUM_CH = 4;
  localparam int SMPL_W = 12;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH*SMPL_W-1:0] smpl = '0;
  logic [NUM_CH-1:0]        smpl_req = '0;
  logic [NUM_CH-1:0]        reseed = '0;
  logic [NUM_CH*3-1:0]      shift = '0;
  logic                     ovr_clr = 1'b0;
`ifdef EXP_AVG_SNAP_EN
  logic [SMPL_W-1:0]        snap_thr = '0;
`endif
  logic [NUM_CH*SMPL_W-1:0] avg;
  logic [NUM_CH-1:0]        avg_vld;
  logic [NUM_CH-1:0]        ovr;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  exp_avg_bank #(.NUM_CH(NUM_CH), .SMPL_W(SMPL_W), .MAX_SHIFT(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .smpl     (smpl),
    .smpl_req (smpl_req),
    .reseed   (reseed),
    .shift    (shift),
    .ovr_clr  (ovr_clr),
`ifdef EXP_AVG_SNAP_EN
    .snap_thr (snap_thr),
`endif
    .avg      (avg),
    .avg_vld  (avg_vld),
    .ovr      (ovr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_smpl(input int ch, input logic [SMPL_W-1:0] v);
    smpl[ch*SMPL_W +: SMPL_W] = v;
  endtask

  task automatic set_shift(input int ch, input logic [2:0] k);
    shift[ch*3 +: 3] = k;
  endtask

  function automatic logic [SMPL_W-1:0] avg_of(input int ch);
    return avg[ch*SMPL_W +: SMPL_W];
  endfunction

  task automatic pulse(input logic [NUM_CH-1:0] req_m, input logic [NUM_CH-1:0] rsd_m);
    smpl_req = req_m;
    reseed   = rsd_m;
    tick();
    smpl_req = '0;
    reseed   = '0;
  endtask

  // cyc counts clocks since the request was driven; -1 means never seen.
  task automatic wait_vld(input int ch, output int cyc);
    cyc = 1;
    while (!avg_vld[ch] && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!avg_vld[ch]) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (avg !== '0) begin errors++; $display("FAIL reset_avg: got %0h expected 0", avg); end
    checks++; if (avg_vld !== '0) begin errors++; $display("FAIL reset_vld: got %0h expected 0", avg_vld); end
    checks++; if (ovr !== '0) begin errors++; $display("FAIL reset_ovr: got %0h expected 0", ovr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_reseed_latency();
    int cyc;
    set_shift(0, 3'd2);
    set_smpl(0, 12'h400);
    pulse(4'b0000, 4'b0001);
    wait_vld(0, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL reseed_latency: got %0d expected 3", cyc); end
    checks++; if (avg_of(0) !== 12'h400) begin errors++; $display("FAIL reseed_avg0: got %0h expected 400", avg_of(0)); end
    tick();
    checks++; if (avg_vld !== '0) begin errors++; $display("FAIL vld_one_cycle: got %0h expected 0", avg_vld); end
  endtask

  task automatic test_k1_sequence();
    int cyc;
    logic [SMPL_W-1:0] exp_seq [3];
    exp_seq[0] = 12'h400; exp_seq[1] = 12'h600; exp_seq[2] = 12'h700;
    set_shift(1, 3'd1);
    set_smpl(1, 12'h000);
    pulse(4'b0000, 4'b0010);
    wait_vld(1, cyc);
    for (int n = 0; n < 3; n++) begin
      set_smpl(1, 12'h800);
      pulse(4'b0010, 4'b0000);
      wait_vld(1, cyc);
      checks++;
      if (cyc !== 3 || avg_of(1) !== exp_seq[n]) begin
        errors++;
        $display("FAIL k1_seq%0d: got avg %0h lat %0d expected avg %0h lat 3", n, avg_of(1), cyc, exp_seq[n]);
      end
    end
  endtask

  task automatic test_shift_clamp();
    int cyc;
    set_shift(3, 3'd7);
    set_smpl(3, 12'h020);
    pulse(4'b0000, 4'b1000);
    wait_vld(3, cyc);
    checks++; if (avg_of(3) !== 12'h020) begin errors++; $display("FAIL clamp_reseed: got %0h expected 020", avg_of(3)); end
    set_smpl(3, 12'h040);
    pulse(4'b1000, 4'b0000);
    wait_vld(3, cyc);
    checks++; if (avg_of(3) !== 12'h021) begin errors++; $display("FAIL clamp_update: got %0h expected 021", avg_of(3)); end
    set_shift(3, 3'd0);
    set_smpl(3, 12'h123);
    pulse(4'b1000, 4'b0000);
    wait_vld(3, cyc);
    checks++; if (avg_of(3) !== 12'h123) begin errors++; $display("FAIL k0_first: got %0h expected 123", avg_of(3)); end
    set_smpl(3, 12'h456);
    pulse(4'b1000, 4'b0000);
    wait_vld(3, cyc);
    checks++; if (avg_of(3) !== 12'h456) begin errors++; $display("FAIL k0_second: got %0h expected 456", avg_of(3)); end
    tick();
  endtask

  task automatic test_all_channels();
    int vt [NUM_CH];
    logic [SMPL_W-1:0] va [NUM_CH];
    logic [SMPL_W-1:0] vexp [NUM_CH];
    int seen, cyc;
    logic busy_bad;
    vexp[0] = 12'h111; vexp[1] = 12'h222; vexp[2] = 12'h333; vexp[3] = 12'h444;
    for (int c = 0; c < NUM_CH; c++) begin
      set_shift(c, 3'd0);
      set_smpl(c, vexp[c]);
      vt[c] = -1;
      va[c] = '0;
    end
    pulse(4'b1111, 4'b0000);
    seen = 0; cyc = 1; busy_bad = 1'b0;
    while (seen < NUM_CH && cyc < 30) begin
      if (cyc <= 8 && busy !== 1'b1) busy_bad = 1'b1;
      for (int c = 0; c < NUM_CH; c++)
        if (avg_vld[c]) begin vt[c] = cyc; va[c] = avg_of(c); seen++; end
      if (seen < NUM_CH) begin tick(); cyc++; end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (vt[c] !== 3 + 2*c || va[c] !== vexp[c]) begin
        errors++;
        $display("FAIL rr_ch%0d: got cycle %0d avg %0h expected cycle %0d avg %0h", c, vt[c], va[c], 3 + 2*c, vexp[c]);
      end
    end
    checks++; if (busy_bad !== 1'b0) begin errors++; $display("FAIL rr_busy: got gap %0b expected 0", busy_bad); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got busy %0b expected 0", busy); end
  endtask

  task automatic test_overrun();
    int npulse;
    logic [SMPL_W-1:0] got;
    set_smpl(0, 12'h0A1); set_smpl(1, 12'h0A2); set_smpl(2, 12'h100); set_smpl(3, 12'h0A4);
    pulse(4'b1111, 4'b0000);
    set_smpl(2, 12'h200);
    pulse(4'b0100, 4'b0000);
    checks++; if (ovr !== 4'b0100) begin errors++; $display("FAIL ovr_set: got %0h expected 4", ovr); end
    npulse = 0; got = '0;
    for (int n = 0; n < 20; n++) begin
      if (avg_vld[2]) begin npulse++; got = avg_of(2); end
      tick();
    end
    checks++; if (npulse !== 1) begin errors++; $display("FAIL ovr_once: got %0d pulses expected 1", npulse); end
    checks++; if (got !== 12'h200) begin errors++; $display("FAIL ovr_latest: got %0h expected 200", got); end
    checks++; if (ovr !== 4'b0100) begin errors++; $display("FAIL ovr_sticky: got %0h expected 4", ovr); end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checks++; if (ovr !== '0) begin errors++; $display("FAIL ovr_clr: got %0h expected 0", ovr); end
  endtask

  task automatic test_reset_mid_update();
    logic bad;
    set_smpl(0, 12'h055);
    pulse(4'b0001, 4'b0000);
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (avg !== '0 || avg_vld !== '0 || ovr !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outs: got avg %0h vld %0h ovr %0h busy %0b expected all 0", avg, avg_vld, ovr, busy);
    end
    tick(); tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (avg_vld !== '0 || busy !== 1'b0 || avg !== '0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mid_reset_quiet: got activity %0b expected 0", bad); end
  endtask

`ifdef EXP_AVG_SNAP_EN
  task automatic test_snap();
    int cyc;
    snap_thr = 12'h040;
    set_shift(0, 3'd2);
    set_smpl(0, 12'h100);
    pulse(4'b0000, 4'b0001);
    wait_vld(0, cyc);
    checks++; if (avg_of(0) !== 12'h100) begin errors++; $display("FAIL snap_seed: got %0h expected 100", avg_of(0)); end
    set_smpl(0, 12'h200);
    pulse(4'b0001, 4'b0000);
    wait_vld(0, cyc);
    checks++; if (avg_of(0) !== 12'h200) begin errors++; $display("FAIL snap_jump: got %0h expected 200", avg_of(0)); end
  endtask
`endif

  initial begin
    test_reset();
    test_reseed_latency();
    test_k1_sequence();
    test_shift_clamp();
    test_all_channels();
    test_overrun();
    test_reset_mid_update();
`ifdef EXP_AVG_SNAP_EN
    test_snap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exp_avg_bank.md
EXP_AVG_BANK -- requirements
Module: exp_avg_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of independent averaging channels (1..16).
REQ-002 SHALL have parameter SMPL_W, default 12, the unsigned sample width in bits.
REQ-003 SHALL have parameter MAX_SHIFT, default 5, the largest weight exponent k; accumulator width is SMPL_W+MAX_SHIFT.
REQ-004 SHALL have port clk  input  1  the single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port smpl  input  NUM_CH*SMPL_W  packed per-channel samples, channel i at bits [i*SMPL_W +: SMPL_W].
REQ-007 SHALL have port smpl_req  input  NUM_CH  one-cycle pulse per channel requesting inclusion of the current smpl.
REQ-008 SHALL have port reseed  input  NUM_CH  one-cycle pulse per channel to reload the average from the current smpl.
REQ-009 SHALL have port shift  input  NUM_CH*3  per-channel weight exponent k.
REQ-010 SHALL have port ovr_clr  input  1  clears all overrun flags.
REQ-011 SHALL have port avg  output  NUM_CH*SMPL_W  per-channel average, registered.
REQ-012 SHALL have port avg_vld  output  NUM_CH  one-cycle pulse when that channel's avg updates.
REQ-013 SHALL have port ovr  output  NUM_CH  sticky per-channel overrun flag.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL capture smpl into a per-channel holding register and set the channel pending bit on smpl_req or reseed.
REQ-016 SHALL record a reseed-type flag with the pending bit; reseed wins when reseed and smpl_req arrive together.
REQ-017 SHALL set ovr[i] when a new request arrives while channel i is already pending; the new sample overwrites the held one.
REQ-018 SHALL service pending channels with one shared datapath, using a round-robin grant that starts from the channel after the last serviced one.
REQ-019 SHALL implement FSM states IDLE, LOAD, UPDATE: IDLE->LOAD when any channel is pending; LOAD->UPDATE always; UPDATE->LOAD if any channel is pending, else IDLE.
REQ-020 SHALL, in LOAD, latch the granted index, operands and effective k, and clear that channel's pending bit unless a new request for that channel arrives in the same cycle.
REQ-021 SHALL, in UPDATE, write acc_new = acc - (acc >> k) + sample for a normal update, or acc_new = sample << k for a reseed.
REQ-022 SHALL compute avg[i] = acc[i] >> k truncated to SMPL_W bits, register it in UPDATE, and pulse avg_vld[i] in the following cycle.
REQ-023 SHALL give a latency of 3 clocks from smpl_req (sampled in IDLE) to the avg_vld pulse.
REQ-024 SHALL clamp k to MAX_SHIFT when shift exceeds MAX_SHIFT; k=0 SHALL make avg equal the latest sample.
REQ-025 SHALL apply a change of shift only at that channel's next service; the accumulator is not rescaled.
REQ-026 SHALL never overflow the accumulator: the steady state is bounded by sample*2^k, which always fits in SMPL_W+MAX_SHIFT bits.
REQ-027 SHALL clear all ovr bits on ovr_clr; a set event in the same cycle as ovr_clr wins.

Reset
REQ-028 SHALL, on rst_n low at any time (mid-service included), clear accumulators, avg, avg_vld, ovr, pending bits, holding registers and the round-robin pointer (pointer=0), and force FSM to IDLE.
REQ-029 SHALL drive busy=0 during and immediately after reset.

Configuration
REQ-030 SHALL, with macro EXP_AVG_SNAP_EN defined, add input snap_thr (SMPL_W); any normal update with |sample - avg| > snap_thr SHALL be executed as a reseed.
REQ-031 SHALL, without EXP_AVG_SNAP_EN, omit snap_thr and perform only explicit reseeds.

Structure
REQ-032 SHALL place the FSM state enum, the MAX_SHIFT default and an accumulator-width constant function in package exp_avg_pkg.
REQ-033 SHALL implement the round-robin grant as sub-module exp_avg_rr_arb (request vector in, one-hot grant plus index out, pointer update on accept).

Verification
REQ-034 SHALL check: reset, then ch0 reseed with smpl=0x400 and k=2 -> avg[0]=0x400, avg_vld[0] pulses exactly 3 cycles after reseed.
REQ-035 SHALL check: ch1 k=1, acc reseeded to 0x000, then smpl_req with 0x800 -> avg sequence 0x400, 0x600, 0x700.
REQ-036 SHALL check: smpl_req on all 4 channels in one cycle -> services in order 0,1,2,3, with avg_vld pulses spaced 2 cycles apart and busy high throughout.
REQ-037 SHALL check: two smpl_req to ch2 before its service (0x100 then 0x200) -> ovr[2]=1, only 0x200 used; ovr_clr -> ovr[2]=0.
REQ-038 SHALL check: shift=7 with MAX_SHIFT=5 -> behaves as k=5; with k=0 -> avg equals the latest sample.
REQ-039 SHALL check: rst_n asserted during UPDATE -> all outputs 0 next cycle and no avg_vld pulse; with EXP_AVG_SNAP_EN defined, snap_thr=0x40, avg=0x100, sample=0x200 -> avg=0x200.
